alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
- Sequential front-end for the combinational 8-bit ALU (a[7:0], b[7:0], operation[3:0] -> z[8:0], legal opcodes 0..9).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU inputs from registers, waits a fixed settle time, then captures z.
- Returns each result with its opcode over a second valid/ready interface, strictly in command order.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- SETTLE_CYC, 2: cycles from the ALU inputs updating to z being sampled; minimum 1.
- LAST_OP, 9: highest legal opcode; opcodes above it are illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle; equals !full, and is forced 0 while rst=1.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_op  in  4  opcode.
- alu_a  out  8  registered drive to ALU a.
- alu_b  out  8  registered drive to ALU b.
- alu_op  out  4  registered drive to ALU operation.
- alu_z  in  9  ALU result z.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_z  out  9  captured result.
- res_op  out  4  opcode that produced res_z.
- res_err  out  1  result belongs to an illegal opcode.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - FIFO empty, fifo_count=0, FSM in IDLE, settle counter 0.
  - All outputs 0: alu_a, alu_b, alu_op, res_valid, res_z, res_op, res_err, busy, cmd_ready.
  - Reset asserted mid-operation abandons the in-flight command and all queued commands; no result is emitted for them.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only under FSM control.
  - Read and write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle; no pass-through.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop the head entry.
  - Legal opcode (<= LAST_OP): load alu_a/alu_b/alu_op from the entry, set counter=SETTLE_CYC, go to SETTLE.
  - Illegal opcode: leave alu_* unchanged, load res_z=0, res_op=the opcode, res_err=1, go to HOLD.
- SETTLE:
  - Decrement the counter each cycle.
  - On the edge where the counter equals 1: capture res_z=alu_z, res_op=alu_op, res_err=0, go to HOLD.
  - Latency: the pop edge is N; sampling happens at edge N+SETTLE_CYC; res_valid is high from then on.
- HOLD:
  - res_valid=1; res_z, res_op and res_err are held stable until res_ready=1.
  - On the handshake edge with the FIFO non-empty: pop the next entry and apply the IDLE entry rules in that same edge, giving back-to-back throughput of one result per SETTLE_CYC+1 cycles.
  - On the handshake edge with the FIFO empty: go to IDLE and clear res_valid.
- alu_* outputs change only at a legal pop; they hold their value in all other states.
- Ordering: results are returned strictly in command order, illegal-opcode results included.

Optional Feature:
- Macro: ALU_CMD_ISSUER_STATS_EN.
- When defined, adds two outputs:
  - stat_issued[15:0]: count of legal commands sent to the ALU.
  - stat_illegal[15:0]: count of illegal opcodes.
- Both counters saturate at 16'hFFFF, are cleared by rst, and increment at the pop edge.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Sweep: a=12, b=4, ops 0..9 issued back-to-back, res_ready=1 -> ten results in order, res_op=0..9 in turn, each res_z equal to the ALU z for that op, res_err=0, result spacing SETTLE_CYC+1=3 cycles.
- Illegal opcode: cmd_op=4'd12 queued between op 0 and op 1 -> middle result has res_z=0, res_op=12, res_err=1; alu_op never takes the value 12; ordering preserved.
- Backpressure: res_ready=0 while pushing 6 commands, DEPTH=4 -> one command in HOLD, fifo_count reaches 4, cmd_ready=0, res_z stable. Releasing res_ready -> all results delivered in order and cmd_ready returns to 1.
- Reset mid-SETTLE: rst=1 one cycle after a pop with 2 commands queued -> next cycle all outputs 0, fifo_count=0, no res_valid until a new command is pushed.
- Simultaneous push/pop: with fifo_count=2, push during the HOLD handshake edge -> fifo_count stays 2.
- Stats (macro defined): 3 legal commands and 1 illegal command -> stat_issued=3, stat_illegal=1. Force stat_issued to 16'hFFFF, then one more legal command -> stat_issued stays 16'hFFFF.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Sequential front-end for a combinational 8-bit ALU (opcodes 0..LAST_OP legal).
// Commands (a, b, op) arrive over a valid/ready interface and are buffered in a
// DEPTH-entry FIFO. A small FSM pops one command at a time. It drives the ALU
// from registers and waits SETTLE_CYC cycles before sampling z. It then presents
// the result with its opcode on a second valid/ready interface, strictly in
// command order. Illegal opcodes never reach the ALU. They are answered directly
// with res_z=0 and res_err=1.
//
// Optional feature (macro ALU_CMD_ISSUER_STATS_EN):
//   adds saturating 16-bit counters stat_issued / stat_illegal, both
//   incremented at the pop edge.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (cmd_ready = !full, 0 during rst)
//   cmd_a, cmd_b, cmd_op command operands and opcode
//   alu_a, alu_b, alu_op registered drive to the ALU
//   alu_z               ALU result input
//   res_valid/res_ready result handshake
//   res_z, res_op, res_err captured result, its opcode, illegal-opcode flag
//   busy                FSM not idle or FIFO non-empty (registered)
//   fifo_count          current FIFO occupancy
//   stat_issued, stat_illegal   (ALU_CMD_ISSUER_STATS_EN only)
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LAST_OP    = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    input  logic [3:0]             cmd_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_op,
    input  logic [8:0]             alu_z,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [8:0]             res_z,
    output logic [3:0]             res_op,
    output logic                   res_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_CMD_ISSUER_STATS_EN
    ,
    output logic [15:0]            stat_issued,
    output logic [15:0]            stat_illegal
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ZERO  = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam logic [3:0]       LAST_OP_V = 4'(LAST_OP);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_t;

    localparam cmd_t CMD_ZERO = '{a: 8'd0, b: 8'd0, op: 4'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Registered state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             res_valid_q, res_valid_d;
    logic [8:0]       res_z_q, res_z_d;
    logic [3:0]       res_op_q, res_op_d;
    logic             res_err_q, res_err_d;
    logic             busy_q, busy_d;

    // Combinational helpers
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    cmd_t             head_s;
    logic             head_legal_s;

    // full blocks the producer even when a pop happens in the same cycle
    assign full_s    = (count_q == FULL_LVL);
    assign empty_s   = (count_q == LVL_ZERO);
    assign cmd_ready = (~full_s) & (~rst);
    assign push_s    = cmd_valid & cmd_ready;

    // Next-state logic: sequencing FSM, ALU/result registers and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        res_valid_d  = res_valid_q;
        res_z_d      = res_z_q;
        res_op_d     = res_op_q;
        res_err_d    = res_err_q;
        pop_s        = 1'b0;
        head_s       = mem_q[rd_ptr_q];
        head_legal_s = (head_s.op <= LAST_OP_V);
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Counter reaching 1 marks the edge SETTLE_CYC after the pop
                if (cnt_q == CNT_ONE) begin
                    res_z_d     = alu_z;
                    res_op_d    = alu_op_q;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    cnt_d       = CNT_ZERO;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    if (!empty_s) begin
                        pop_s = 1'b1;
                    end else begin
                        res_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
                cnt_d       = CNT_ZERO;
            end
        endcase

        // A popped entry is dispatched identically from IDLE and from a HOLD
        // handshake, which gives back-to-back results without an idle cycle.
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (head_legal_s) begin
                alu_a_d     = head_s.a;
                alu_b_d     = head_s.b;
                alu_op_d    = head_s.op;
                cnt_d       = SETTLE_LD;
                res_valid_d = 1'b0;
                state_d     = ST_SETTLE;
            end else begin
                // Illegal opcodes bypass the ALU; alu_* keep their last value
                res_z_d     = 9'd0;
                res_op_d    = head_s.op;
                res_err_d   = 1'b1;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s) begin
            mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase

        busy_d = (state_d != ST_IDLE) || (count_d != LVL_ZERO);
    end

    // State registers; reset discards the in-flight command and the whole queue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            mem_q       <= '{default: CMD_ZERO};
            rd_ptr_q    <= PTR_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            count_q     <= LVL_ZERO;
            alu_a_q     <= 8'd0;
            alu_b_q     <= 8'd0;
            alu_op_q    <= 4'd0;
            res_valid_q <= 1'b0;
            res_z_q     <= 9'd0;
            res_op_q    <= 4'd0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign res_valid  = res_valid_q;
    assign res_z      = res_z_q;
    assign res_op     = res_op_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

`ifdef ALU_CMD_ISSUER_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_illegal_q, stat_illegal_d;

    // Saturating dispatch statistics, updated at the pop edge
    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_illegal_d = stat_illegal_q;
        if (pop_s && head_legal_s && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end else begin
            stat_issued_d = stat_issued_q;
        end
        if (pop_s && !head_legal_s && (stat_illegal_q != 16'hFFFF)) begin
            stat_illegal_d = stat_illegal_q + 16'd1;
        end else begin
            stat_illegal_d = stat_illegal_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q  <= 16'd0;
            stat_illegal_q <= 16'd0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
